// File: rtl/residual_skip_merge_pkg.sv
// Shared types and helpers for the residual skip-merge stage.
package residual_skip_merge_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Index width for a power-of-2 range, never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/residual_skip_merge_skip_fifo.sv
// Register-array FIFO holding skip beats until the main path catches up.
module skip_fifo
  import residual_skip_merge_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/residual_skip_merge.sv
// Residual merge: buffers skip beats, adds them lane-wise to later main-path beats
// with saturation, optional ReLU, frame counting and sticky error flags.
module residual_skip_merge
  import residual_skip_merge_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CH         = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int RELU_EN    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDHT*CH-1:0] Skip_In,
  input  logic                     Skip_Valid,
  input  logic [DATA_WIDHT*CH-1:0] Main_In,
  input  logic                     Main_Valid,
  output logic [DATA_WIDHT*CH-1:0] Data_Out,
  output logic                     Valid_Out,
  output logic                     Frame_Done,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int W     = DATA_WIDHT;
  localparam int BUS   = DATA_WIDHT * CH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME = IMG_WIDHT * IMG_HEIGHT;
  localparam int BW    = ptr_w(FRAME);

  // Assertion is immediate; release passes through two flops so nothing moves on a ragged edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [BUS-1:0] skip_head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           pop_ok;
  logic           push_ok;

  assign pop_ok  = Main_Valid && !empty;
  assign push_ok = Skip_Valid && (!full || pop_ok);

  skip_fifo #(.WIDTH(BUS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (Skip_Valid),
    .pop     (Main_Valid),
    .wr_data (Skip_In),
    .rd_data (skip_head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  logic [BUS-1:0] merged;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic [W-1:0] skip_l;
    logic [W-1:0] main_l;
    logic [W:0]   sum;
    logic [W-1:0] sat;

    assign skip_l = skip_head[i*W +: W];
    assign main_l = Main_In[i*W +: W];
    assign sum    = {skip_l[W-1], skip_l} + {main_l[W-1], main_l};
    // Top two sum bits disagree only when the true result left the W-bit range.
    assign sat    = (sum[W] != sum[W-1]) ? (sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                         : sum[W-1:0];
    assign merged[i*W +: W] = ((RELU_EN != 0) && sat[W-1]) ? '0 : sat;
  end

  logic [BW-1:0] beat_cnt;
  logic          last_beat;

  assign last_beat = (beat_cnt == BW'(FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_Out   <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      Valid_Out  <= pop_ok;
      Frame_Done <= pop_ok && last_beat;
      if (pop_ok) begin
        Data_Out <= merged;
        beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
      end
      if (Skip_Valid && full && !pop_ok) Overflow  <= 1'b1;
      if (Main_Valid && empty)           Underflow <= 1'b1;
    end
  end

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment up front keeps this block from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (push_ok) state_next = ST_RUN;
      ST_RUN:  if (pop_ok && !push_ok && count == CW'(1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_residual_skip_merge.sv
// Scoreboard bench: two instances (ReLU off / on) share stimulus; each has its own expected queue.
module tb_residual_skip_merge;

  localparam int W   = 32;
  localparam int CH  = 2;
  localparam int BUS = W * CH;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [BUS-1:0] skip_in = '0;
  logic [BUS-1:0] main_in = '0;
  logic           skip_valid = 1'b0;
  logic           main_valid = 1'b0;

  logic [BUS-1:0] dout [2];
  logic           vo [2];
  logic           fd [2];
  logic           ov [2];
  logic           un [2];

  residual_skip_merge #(
    .DATA_WIDHT(W), .CH(CH), .FIFO_DEPTH(4), .IMG_WIDHT(4), .IMG_HEIGHT(2), .RELU_EN(0)
  ) dut_lin (
    .clk(clk), .rst(rst), .Skip_In(skip_in), .Skip_Valid(skip_valid),
    .Main_In(main_in), .Main_Valid(main_valid), .Data_Out(dout[0]), .Valid_Out(vo[0]),
    .Frame_Done(fd[0]), .Overflow(ov[0]), .Underflow(un[0])
  );

  residual_skip_merge #(
    .DATA_WIDHT(W), .CH(CH), .FIFO_DEPTH(4), .IMG_WIDHT(4), .IMG_HEIGHT(2), .RELU_EN(1)
  ) dut_relu (
    .clk(clk), .rst(rst), .Skip_In(skip_in), .Skip_Valid(skip_valid),
    .Main_In(main_in), .Main_Valid(main_valid), .Data_Out(dout[1]), .Valid_Out(vo[1]),
    .Frame_Done(fd[1]), .Overflow(ov[1]), .Underflow(un[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BUS-1:0] data;
    logic           fd;
    int             cyc;
  } exp_t;

  exp_t q [2][$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_beat = 0;

  task automatic check(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One clock of stimulus; when a merged beat is due, its expected values go to both queues.
  task automatic step(input logic sv, input logic [31:0] s0, input logic [31:0] s1,
                      input logic mv, input logic [31:0] m0, input logic [31:0] m1,
                      input logic [31:0] l0, input logic [31:0] l1,
                      input logic [31:0] r0, input logic [31:0] r1, input bit expect_out);
    exp_t e;
    skip_valid = sv;
    skip_in    = {s1, s0};
    main_valid = mv;
    main_in    = {m1, m0};
    @(posedge clk);
    #1;
    if (expect_out) begin
      e.fd   = (exp_beat == 7);
      e.cyc  = cyc;
      e.data = {l1, l0};
      q[0].push_back(e);
      e.data = {r1, r0};
      q[1].push_back(e);
      exp_beat = (exp_beat + 1) % 8;
    end
    skip_valid = 1'b0;
    main_valid = 1'b0;
  endtask

  task automatic skip(input logic [31:0] s0, input logic [31:0] s1);
    step(1'b1, s0, s1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic merge(input logic [31:0] m0, input logic [31:0] m1,
                       input logic [31:0] l0, input logic [31:0] l1,
                       input logic [31:0] r0, input logic [31:0] r1);
    step(1'b0, 0, 0, 1'b1, m0, m1, l0, l1, r0, r1, 1'b1);
  endtask

  task automatic check_flags(input string tag, input logic ov_req, input logic un_req);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_overflow[%0d]", tag, i), BUS'(ov[i]), BUS'(ov_req));
      check($sformatf("%s_underflow[%0d]", tag, i), BUS'(un[i]), BUS'(un_req));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), dout[i], '0);
      check($sformatf("%s_valid[%0d]", tag, i), BUS'(vo[i]), '0);
      check($sformatf("%s_frame_done[%0d]", tag, i), BUS'(fd[i]), '0);
    end
    check_flags(tag, 1'b0, 1'b0);
  endtask

  // Monitor: pops and compares whenever a DUT presents a beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (vo[i]) begin
          if (q[i].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat[%0d]: got %h, required no beat", i, dout[i]);
          end else begin
            e = q[i].pop_front();
            check($sformatf("data[%0d]", i), dout[i], e.data);
            check($sformatf("frame_done[%0d]", i), BUS'(fd[i]), BUS'(e.fd));
            check($sformatf("latency_cycle[%0d]", i), BUS'(cyc), BUS'(e.cyc));
          end
        end else if (fd[i]) begin
          check($sformatf("frame_done_without_valid[%0d]", i), BUS'(fd[i]), '0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic merge: 10 + 5 = 15 per lane, after the main path lags by four beats.
    for (int i = 0; i < 4; i++) skip(10, 10);
    for (int i = 0; i < 4; i++) merge(5, 5, 15, 15, 15, 15);

    // Saturation at both rails and ReLU on negative sums.
    skip(32'h7FFF_FFF0, 32'h8000_0000);
    merge(32'h0000_0100, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
    skip(32'hFFFF_FFFD, 7);
    merge(1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 5, 0, 5);
    skip(32'h8000_0000, 32'h7FFF_FFFF);
    merge(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF);

    // Fill to depth 4, push+pop while full, then one dropped push.
    for (int k = 1; k <= 4; k++) skip(k, k + 100);
    check_flags("full_no_drop", 1'b0, 1'b0);
    step(1'b1, 5, 105, 1'b1, 0, 0, 1, 101, 1, 101, 1'b1);
    check_flags("full_push_pop", 1'b0, 1'b0);
    skip(6, 106);
    check_flags("drop", 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) merge(0, 0, k, k + 100, k, k + 100);

    // Main beat on an empty FIFO with a simultaneous push: no bypass.
    step(1'b1, 20, 30, 1'b1, 1, 1, 0, 0, 0, 0, 1'b0);
    check_flags("underflow", 1'b1, 1'b1);
    merge(2, 2, 22, 32, 22, 32);

    // Run through the second frame boundary.
    for (int i = 0; i < 4; i++) begin
      skip(i, -i);
      merge(100, 100, 100 + i, 100 - i, 100 + i, 100 - i);
    end

    // Mid-frame reset with three beats still buffered.
    for (int i = 0; i < 4; i++) skip(50, 50);
    merge(1, 1, 51, 51, 51, 51);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("queue_drained_lin", BUS'(q[0].size()), '0);
    check("queue_drained_relu", BUS'(q[1].size()), '0);
    exp_beat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("post_release");

    // Fresh frame: Frame_Done must land on the 8th beat after reset.
    for (int i = 0; i < 8; i++) begin
      skip(i + 1, 7);
      merge(i, i, 2 * i + 1, i + 7, 2 * i + 1, i + 7);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_lin", BUS'(q[0].size()), '0);
    check("final_queue_relu", BUS'(q[1].size()), '0);
    check_flags("final", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
